// File: rtl/conv_og_batch_sequencer.sv
// Batch sequencer driving conv_top through every output group (OG):
// weights, go, pixel replay, drain, zero flush, reset hold, settle.
module conv_og_batch_sequencer #(
   parameter int WT_DEPTH      = 4096,
   parameter int WT_ADDR_WIDTH = $clog2(WT_DEPTH),
   parameter int MAX_OG_BITS   = 8,
   parameter int RST_HOLD      = 5,
   parameter int SETTLE        = 2,
   parameter int FLUSH_EXTRA   = 4,
   parameter int DONE_TIMEOUT  = 65536
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [MAX_OG_BITS-1:0]   cfg_co_groups,
   input  logic [9:0]               cfg_ci_groups,
   input  logic [15:0]              cfg_padded_w,
   input  logic [15:0]              cfg_padded_h,
   input  logic                     cfg_wt_resident,
   input  logic [15:0]              cfg_expected_beats,
   output logic                     wt_load_req,
   output logic [MAX_OG_BITS-1:0]   wt_load_og,
   input  logic                     wt_load_done,
   input  logic [63:0]              src_pixel,
   input  logic                     src_valid,
   output logic                     src_ready,
   output logic [63:0]              pixel_out,
   output logic                     pixel_out_valid,
   output logic                     pixel_out_last,
   output logic                     conv_go,
   output logic                     conv_rst,
   input  logic                     conv_done,
   input  logic                     conv_data_valid,
   output logic [MAX_OG_BITS-1:0]   cfg_output_group,
   output logic [WT_ADDR_WIDTH-1:0] cfg_wt_base_addr,
   output logic                     busy,
   output logic                     batch_done,
   output logic                     err_beats,
   output logic                     err_timeout,
   output logic                     err_cfg,
   output logic [MAX_OG_BITS-1:0]   err_og
);

   localparam logic [31:0] DEPTH_W = WT_DEPTH;
   localparam logic [31:0] HOLD_W  = RST_HOLD;
   localparam logic [31:0] SETL_W  = SETTLE;
   localparam logic [31:0] EXTRA_W = FLUSH_EXTRA;
   localparam logic [31:0] TMO_W   = DONE_TIMEOUT;

   typedef enum logic [3:0] {
      S_IDLE, S_SETUP, S_WT_REQ, S_GO, S_STREAM,
      S_DRAIN, S_FLUSH, S_RST, S_SETTLE, S_NEXT
   } state_t;

   state_t                 state;
   logic [MAX_OG_BITS-1:0] og, co;
   logic [9:0]             ci;
   logic [15:0]            pw, ph, exp_beats;
   logic                   resident, done_seen;
   logic [31:0]            npix, nflush, wpog, cnt, beats;

   logic        conv_win, done_now, cfg_bad, beats_bad;
   logic [31:0] beats_nxt, wt_need;

   assign conv_win  = (state == S_GO) || (state == S_STREAM) ||
                      (state == S_DRAIN);
   assign beats_nxt = beats + {31'd0, conv_win && conv_data_valid};
   assign beats_bad = beats_nxt != {16'd0, exp_beats};
   assign done_now  = done_seen || conv_done;
   assign wt_need   = 32'(co) * wpog;
   assign cfg_bad   = (co == '0) || (ci == '0) ||
                      (pw < 16'd3) || (ph < 16'd3) ||
                      (resident && (wt_need > DEPTH_W));

   assign wt_load_req      = (state == S_WT_REQ) && !resident;
   assign wt_load_og       = og;
   assign src_ready        = state == S_STREAM;
   assign conv_go          = state == S_GO;
   assign conv_rst         = state == S_RST;
   assign busy             = state != S_IDLE;
   assign cfg_output_group = og;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         og               <= '0;
         co               <= '0;
         ci               <= '0;
         pw               <= '0;
         ph               <= '0;
         exp_beats        <= '0;
         resident         <= 1'b0;
         done_seen        <= 1'b0;
         npix             <= '0;
         nflush           <= '0;
         wpog             <= '0;
         cnt              <= '0;
         beats            <= '0;
         pixel_out        <= '0;
         pixel_out_valid  <= 1'b0;
         pixel_out_last   <= 1'b0;
         cfg_wt_base_addr <= '0;
         batch_done       <= 1'b0;
         err_beats        <= 1'b0;
         err_timeout      <= 1'b0;
         err_cfg          <= 1'b0;
         err_og           <= '0;
      end else begin
         pixel_out       <= '0;
         pixel_out_valid <= 1'b0;
         pixel_out_last  <= 1'b0;
         batch_done      <= 1'b0;
         if (conv_win) begin
            beats <= beats_nxt;
            if (conv_done) done_seen <= 1'b1;
         end
         unique case (state)
            S_IDLE: if (start) begin
               co          <= cfg_co_groups;
               ci          <= cfg_ci_groups;
               pw          <= cfg_padded_w;
               ph          <= cfg_padded_h;
               resident    <= cfg_wt_resident;
               exp_beats   <= cfg_expected_beats;
               npix        <= 32'(cfg_padded_w) * 32'(cfg_padded_h) *
                              32'(cfg_ci_groups);
               nflush      <= 32'd2 * 32'(cfg_padded_w) *
                              32'(cfg_ci_groups) + EXTRA_W;
               wpog        <= 32'(cfg_ci_groups) * 32'd64;
               og          <= '0;
               cnt         <= '0;
               beats       <= '0;
               done_seen   <= 1'b0;
               err_beats   <= 1'b0;
               err_timeout <= 1'b0;
               err_cfg     <= 1'b0;
               err_og      <= '0;
               state       <= S_SETUP;
            end
            S_SETUP: begin
               cfg_wt_base_addr <= '0;
               if (cfg_bad) begin
                  err_cfg    <= 1'b1;
                  err_og     <= og;
                  batch_done <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  state <= S_WT_REQ;
               end
            end
            S_WT_REQ: if (resident || wt_load_done) state <= S_GO;
            S_GO: begin
               cnt   <= '0;
               state <= S_STREAM;
            end
            S_STREAM: if (src_valid) begin
               pixel_out       <= src_pixel;
               pixel_out_valid <= 1'b1;
               pixel_out_last  <= (cnt + 1 == npix);
               if (cnt + 1 == npix) begin
                  cnt   <= '0;
                  state <= S_DRAIN;
               end else begin
                  cnt <= cnt + 1;
               end
            end
            S_DRAIN: begin
               if (done_now || (cnt == TMO_W - 1)) begin
                  if (!done_now) err_timeout <= 1'b1;
                  if (beats_bad) err_beats <= 1'b1;
                  // err_og keeps the OG of the earliest failure only
                  if (!(err_beats || err_timeout || err_cfg) &&
                      (!done_now || beats_bad))
                     err_og <= og;
                  cnt   <= '0;
                  state <= S_FLUSH;
               end else begin
                  cnt <= cnt + 1;
               end
            end
            S_FLUSH: begin
               pixel_out_valid <= 1'b1;
               if (cnt == nflush - 1) begin
                  cnt   <= '0;
                  state <= S_RST;
               end else begin
                  cnt <= cnt + 1;
               end
            end
            S_RST: begin
               if (cnt == HOLD_W - 1) begin
                  cnt   <= '0;
                  state <= S_SETTLE;
               end else begin
                  cnt <= cnt + 1;
               end
            end
            S_SETTLE: begin
               if (cnt == SETL_W - 1) begin
                  cnt   <= '0;
                  state <= S_NEXT;
               end else begin
                  cnt <= cnt + 1;
               end
            end
            S_NEXT: begin
               beats     <= '0;
               done_seen <= 1'b0;
               if (og == co - 1'b1) begin
                  batch_done <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  og <= og + 1'b1;
                  cfg_wt_base_addr <= resident ?
                     cfg_wt_base_addr + wpog[WT_ADDR_WIDTH-1:0] : '0;
                  state <= S_WT_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_og_batch_sequencer.sv
// Directed bench for conv_og_batch_sequencer with a small conv_top,
// weight-loader and pixel-source model driven on the falling edge.
module tb_conv_og_batch_sequencer;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  cfg_co_groups;
   logic [9:0]  cfg_ci_groups;
   logic [15:0] cfg_padded_w, cfg_padded_h, cfg_expected_beats;
   logic        cfg_wt_resident;
   logic        wt_load_req, wt_load_done;
   logic [7:0]  wt_load_og;
   logic [63:0] src_pixel, pixel_out;
   logic        src_valid, src_ready;
   logic        pixel_out_valid, pixel_out_last;
   logic        conv_go, conv_rst, conv_done, conv_data_valid;
   logic [7:0]  cfg_output_group, err_og;
   logic [11:0] cfg_wt_base_addr;
   logic        busy, batch_done, err_beats, err_timeout, err_cfg;
   logic [47:0] ctl;

   always #5 clk = ~clk;

   assign ctl = {wt_load_req, wt_load_og, src_ready, pixel_out_valid,
                 pixel_out_last, conv_go, conv_rst, cfg_output_group,
                 cfg_wt_base_addr, busy, batch_done, err_beats,
                 err_timeout, err_cfg, err_og};

   conv_og_batch_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_co_groups(cfg_co_groups), .cfg_ci_groups(cfg_ci_groups),
      .cfg_padded_w(cfg_padded_w), .cfg_padded_h(cfg_padded_h),
      .cfg_wt_resident(cfg_wt_resident),
      .cfg_expected_beats(cfg_expected_beats),
      .wt_load_req(wt_load_req), .wt_load_og(wt_load_og),
      .wt_load_done(wt_load_done),
      .src_pixel(src_pixel), .src_valid(src_valid),
      .src_ready(src_ready),
      .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
      .pixel_out_last(pixel_out_last),
      .conv_go(conv_go), .conv_rst(conv_rst),
      .conv_done(conv_done), .conv_data_valid(conv_data_valid),
      .cfg_output_group(cfg_output_group),
      .cfg_wt_base_addr(cfg_wt_base_addr),
      .busy(busy), .batch_done(batch_done),
      .err_beats(err_beats), .err_timeout(err_timeout),
      .err_cfg(err_cfg), .err_og(err_og)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int bd_cnt, go_cnt, og_tb, pix_og, exp_px, src_idx;
   int px_err, bub_err, go_early, wt_req_cnt, wt_done_cnt;
   int wt_dly, done_dly, lat;
   bit after_last, acc_prev, wt_pend, dv_pend;
   bit stall, fault, res_tb;
   int pix[16], last_pos[16], last_cnt[16], flush[16];
   int rstc[16], base_go[16], ogo[16], wt_log[16];

   task automatic check(input string tag, input longint got,
                        input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic clear();
      bd_cnt = 0; go_cnt = 0; og_tb = -1; pix_og = 0;
      exp_px = 1; src_idx = 1; px_err = 0; bub_err = 0;
      go_early = 0; wt_req_cnt = 0; wt_done_cnt = 0;
      wt_dly = 0; done_dly = 0; after_last = 0; acc_prev = 0;
      wt_pend = 0; dv_pend = 0;
      for (int g = 0; g < 16; g++) begin
         pix[g] = 0; last_pos[g] = 0; last_cnt[g] = 0; flush[g] = 0;
         rstc[g] = 0; base_go[g] = -1; ogo[g] = -1; wt_log[g] = -1;
      end
   endtask

   task automatic tick();
      bit ok;
      @(negedge clk);
      cyc++;
      ok = (og_tb >= 0) && (og_tb < 16);
      if (batch_done) bd_cnt++;
      if (conv_go) begin
         go_cnt++;
         og_tb = go_cnt - 1;
         ok = og_tb < 16;
         if (ok) begin
            base_go[og_tb] = int'(cfg_wt_base_addr);
            ogo[og_tb] = int'(cfg_output_group);
         end
         if (!res_tb && wt_done_cnt != go_cnt) go_early++;
         after_last = 0;
         pix_og = 0;
      end
      if (!after_last) begin
         if (pixel_out_valid != acc_prev) bub_err++;
         if (pixel_out_valid) begin
            pix_og++;
            if (ok) pix[og_tb]++;
            if (pixel_out != 64'(exp_px)) px_err++;
            exp_px++;
            if (pix_og % 20 == 0 && pix_og <= 80 &&
                !(fault && og_tb == 5 && pix_og == 80))
               dv_pend = 1;
            if (pixel_out_last) begin
               if (ok) begin
                  last_cnt[og_tb]++;
                  last_pos[og_tb] = pix_og;
               end
               after_last = 1;
               done_dly = 3;
            end
         end
      end else if (pixel_out_valid) begin
         if (ok) flush[og_tb]++;
         if (pixel_out != 64'd0 || pixel_out_last) px_err++;
      end
      if (conv_rst && ok) rstc[og_tb]++;
      if (wt_load_req && !wt_pend) begin
         wt_pend = 1;
         wt_dly = 20;
         if (wt_req_cnt < 16) wt_log[wt_req_cnt] = int'(wt_load_og);
         wt_req_cnt++;
      end
      conv_data_valid = dv_pend;
      dv_pend = 0;
      conv_done = 0;
      if (done_dly > 0) begin
         done_dly--;
         if (done_dly == 0) conv_done = 1;
      end
      wt_load_done = 0;
      if (wt_pend) begin
         wt_dly--;
         if (wt_dly == 0) begin
            wt_load_done = 1;
            wt_pend = 0;
            wt_done_cnt++;
         end
      end
      src_valid = stall ? (cyc % 3 != 0) : 1'b1;
      src_pixel = 64'(src_idx);
      acc_prev = src_valid && src_ready;
      if (acc_prev) src_idx++;
   endtask

   task automatic kick(input int co, input int ci, input bit res,
                       input int exb, input bit stl, input bit flt);
      cfg_co_groups = 8'(co);
      cfg_ci_groups = 10'(ci);
      cfg_padded_w = 16'd6;
      cfg_padded_h = 16'd6;
      cfg_wt_resident = res;
      cfg_expected_beats = 16'(exb);
      stall = stl; fault = flt; res_tb = res;
      clear();
      start = 1;
      tick();
      start = 0;
      lat = 1;
   endtask

   task automatic wait_done();
      while (bd_cnt == 0 && lat < 6000) begin
         tick();
         lat++;
      end
      check("batch_done_seen", bd_cnt > 0, 1);
      repeat (8) tick();
   endtask

   task automatic og_checks(input string t, input int n, input bit res);
      for (int g = 0; g < n; g++) begin
         check({t, "_pix"}, pix[g], 144);
         check({t, "_lastpos"}, last_pos[g], 144);
         check({t, "_lastcnt"}, last_cnt[g], 1);
         check({t, "_flush"}, flush[g], 52);
         check({t, "_rst"}, rstc[g], 5);
         check({t, "_og"}, ogo[g], g);
         check({t, "_base"}, base_go[g], res ? g * 256 : 0);
      end
      check({t, "_bd"}, bd_cnt, 1);
      check({t, "_go"}, go_cnt, n);
      check({t, "_pxerr"}, px_err, 0);
      check({t, "_bubble"}, bub_err, 0);
   endtask

   initial begin
      rst = 1; start = 0;
      cfg_co_groups = 0; cfg_ci_groups = 0;
      cfg_padded_w = 0; cfg_padded_h = 0;
      cfg_wt_resident = 0; cfg_expected_beats = 0;
      wt_load_done = 0; src_pixel = 0; src_valid = 0;
      conv_done = 0; conv_data_valid = 0;
      stall = 0; fault = 0; res_tb = 0;
      clear();
      repeat (3) tick();
      rst = 0;
      tick();
      check("reset_ctl", ctl, 0);
      check("reset_pix", pixel_out, 0);

      // resident weights, ideal source
      kick(8, 4, 1, 4, 0, 0);
      wait_done();
      og_checks("res", 8, 1);
      check("res_err", {err_beats, err_timeout, err_cfg}, 0);

      // per-OG weight reload
      kick(8, 4, 0, 4, 0, 0);
      wait_done();
      og_checks("rel", 8, 0);
      check("rel_reqs", wt_req_cnt, 8);
      for (int g = 0; g < 8; g++) check("rel_wt_og", wt_log[g], g);
      check("rel_go_early", go_early, 0);
      check("rel_err", {err_beats, err_timeout, err_cfg}, 0);

      // stalling source
      kick(8, 4, 1, 4, 1, 0);
      wait_done();
      og_checks("stall", 8, 1);
      check("stall_err", {err_beats, err_timeout, err_cfg}, 0);

      // short beat count in OG5
      kick(8, 4, 1, 4, 0, 1);
      wait_done();
      check("beat_bd", bd_cnt, 1);
      check("beat_go", go_cnt, 8);
      check("beat_err", err_beats, 1);
      check("beat_errog", err_og, 5);
      check("beat_other", {err_timeout, err_cfg}, 0);

      // resident weights overflow memory
      kick(16, 8, 1, 4, 0, 0);
      wait_done();
      check("cfg_err", err_cfg, 1);
      check("cfg_lat_le2", lat <= 2, 1);
      check("cfg_go", go_cnt, 0);
      check("cfg_errog", err_og, 0);
      check("cfg_busy", busy, 0);

      // abort in OG2 flush
      kick(8, 4, 1, 4, 0, 0);
      while (!(og_tb == 2 && after_last && flush[2] >= 5) &&
             lat < 6000) begin
         tick();
         lat++;
      end
      check("abort_reached", lat < 6000, 1);
      rst = 1;
      tick();
      check("abort_ctl", ctl, 0);
      check("abort_pix", pixel_out, 0);
      rst = 0;
      repeat (10) tick();
      check("abort_nobd", bd_cnt, 0);
      check("abort_idle", busy, 0);

      kick(1, 4, 1, 4, 0, 0);
      wait_done();
      og_checks("post", 1, 1);
      check("post_err", {err_beats, err_timeout, err_cfg}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_og_batch_sequencer.md
Name: conv_og_batch_sequencer

Overview:
Hardware controller that runs a full multi-output-group convolution layer on conv_top without host intervention. For each output group (OG) it supplies the weights, sets the OG and weight base address, pulses go, and gates the replayed input pixel stream into conv_top. It then drains, flushes the line buffers with zero beats, and holds conv_top in reset. It checks the output beat count per OG and sits between the AXI wrapper/DMA and conv_top.

Parameters:
WT_DEPTH, 4096, conv_top weight memory depth in words; WT_ADDR_WIDTH = clog2(WT_DEPTH).
MAX_OG_BITS, 8, width of the OG counter and fields.
RST_HOLD, 5, number of cycles conv_rst is held per OG.
SETTLE, 2, idle cycles after conv_rst is released.
FLUSH_EXTRA, 4, extra zero beats added to the flush.
DONE_TIMEOUT, 65536, cycles allowed in DRAIN before a timeout error.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that begins a batch; ignored unless in IDLE
cfg_co_groups  in  MAX_OG_BITS  number of OGs, 1..255
cfg_ci_groups  in  10  input channel groups
cfg_padded_w  in  16  padded image width
cfg_padded_h  in  16  padded image height
cfg_wt_resident  in  1  1 = all OG weights preloaded contiguously; 0 = reload weights per OG
cfg_expected_beats  in  16  data_out_valid beats expected per OG
wt_load_req  out  1  level signal: request weight load for wt_load_og
wt_load_og  out  MAX_OG_BITS  OG whose weights are requested
wt_load_done  in  1  one-cycle pulse: weight load complete
src_pixel  in  64  replayed input pixel
src_valid  in  1  source pixel valid
src_ready  out  1  sequencer accepts a source pixel
pixel_out  out  64  to conv_top pixel_in
pixel_out_valid  out  1  to conv_top pixel_in_valid
pixel_out_last  out  1  to conv_top pixel_in_last
conv_go  out  1  to conv_top go
conv_rst  out  1  to conv_top rst; OR'd with rst at the top level
conv_done  in  1  from conv_top done
conv_data_valid  in  1  from conv_top data_out_valid
cfg_output_group  out  MAX_OG_BITS  current OG
cfg_wt_base_addr  out  WT_ADDR_WIDTH  weight base address for the current OG
busy  out  1  high whenever the FSM is not in IDLE
batch_done  out  1  one-cycle pulse at the end of a batch
err_beats  out  1  sticky: beat-count mismatch
err_timeout  out  1  sticky: DRAIN timeout
err_cfg  out  1  sticky: illegal configuration
err_og  out  MAX_OG_BITS  OG index of the first error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Sticky error flags clear only on rst or on an accepted start.
- Derived quantities, computed in 32-bit at start and registered:
  - NPIX = W*H*ci
  - NFLUSH = 2*W*ci + FLUSH_EXTRA
  - WPOG = ci*64
- Configuration check at start (SETUP state). Any of the following sets err_cfg, pulses batch_done, and returns to IDLE:
  - co = 0, ci = 0, W < 3 or H < 3
  - cfg_wt_resident = 1 and co*WPOG > WT_DEPTH
- FSM states:
  - IDLE -> SETUP on start.
  - SETUP -> WT_REQ.
  - WT_REQ: if resident, go directly to GO. Otherwise assert wt_load_req with wt_load_og = og, hold it until wt_load_done, then go to GO.
  - GO: conv_go = 1 for exactly one cycle, then STREAM.
  - STREAM:
    - src_ready = 1.
    - Each src_valid && src_ready transfers the pixel to pixel_out on the next cycle with pixel_out_valid = 1, registered with 1-cycle latency.
    - pixel_out_last = 1 on pixel number NPIX.
    - After NPIX transfers, go to DRAIN.
    - Source stalls insert pixel_out_valid = 0 bubbles.
  - DRAIN: wait for conv_done. If conv_done already arrived during STREAM, it is latched and DRAIN exits on its first cycle. If the wait exceeds DONE_TIMEOUT, set err_timeout and go to FLUSH.
  - FLUSH: NFLUSH consecutive beats with pixel_out = 0, pixel_out_valid = 1, pixel_out_last = 0, then RST.
  - RST: conv_rst = 1 for RST_HOLD cycles, then SETTLE.
  - SETTLE: SETTLE cycles of idle, then NEXT.
  - NEXT: if og == co-1, pulse batch_done and go to IDLE. Otherwise og++ and go to WT_REQ.
- cfg_output_group = og.
- cfg_wt_base_addr = og*WPOG when resident, 0 otherwise. Updated in SETUP/NEXT and held stable from GO through SETTLE.
- Beat counter: counts conv_data_valid from GO through DRAIN and is cleared in NEXT. At DRAIN exit, if count != cfg_expected_beats, set err_beats. err_og latches the OG of the first error of any kind.
- start while busy is ignored. rst mid-batch aborts immediately to IDLE with no batch_done pulse.
- Simultaneous wt_load_done and conv_done: conv_done is irrelevant outside GO..DRAIN and is ignored.

Test Plan:
- W=6, H=6, ci=4, co=8, resident=1, expected=4, ideal source -> per OG: 144 pixels with last on pixel 144, 52 flush beats, 5 conv_rst cycles; base addresses 0,256,...,1792; 8 conv_go pulses; single batch_done; no errors.
- Same configuration with resident=0 and wt_load_done 20 cycles after each request -> wt_load_og steps 0..7; cfg_wt_base_addr = 0 throughout; conv_go never precedes the matching wt_load_done.
- Source deasserts src_valid every 3rd cycle -> pixel_out_valid has matching bubbles; still exactly 144 pixels per OG; last flagged only on pixel 144.
- conv_data_valid pulses only 3 times in OG5 -> err_beats = 1, err_og = 5; the batch continues to batch_done.
- resident=1, ci=8, co=16 (16*512 > 4096) -> err_cfg = 1 and batch_done within 2 cycles; conv_go never asserted.
- rst asserted during FLUSH of OG2 -> next cycle all outputs 0, no batch_done; a new start runs OG0 cleanly.
